clk_enable_gen: RTL

//  Multi-channel fractional clock-enable generator with PLL lock supervision.

---
 rtl/clk_enable_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator behind the system PLL.
// Phase accumulators produce per-channel enables; a lock supervisor gates the core reset.
module clk_enable_gen #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter logic [NCH*ACC_W-1:0] INC_INIT = '0,
    localparam int unsigned SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pll_lock,
    input  logic             inc_wr,
    input  logic [SEL_W-1:0] inc_sel,
    input  logic [ACC_W-1:0] inc_data,
    output logic             inc_ready,
    output logic [NCH-1:0]   ce,
    output logic             run,
    output logic             sys_rst_n
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_m;
    logic             lock_s;

    logic [ACC_W-1:0] acc  [NCH];
    logic [ACC_W-1:0] inc  [NCH];
    logic [ACC_W-1:0] pval [NCH];
    logic [ACC_W:0]   sum  [NCH];
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   wr_hit;
    logic             accum_en;
    logic             ready_c;

    // Two-stage synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // Lock supervisor: RUN once the synced lock has held for LOCK_CYCLES cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_WAIT;
            cnt       <= '0;
            run       <= 1'b0;
            sys_rst_n <= 1'b0;
        end else begin
            sys_rst_n <= run;
            case (state)
                ST_WAIT: begin
                    cnt <= '0;
                    if (lock_s) begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(LOCK_CYCLES - 2)) begin
                            state <= ST_RUN;
                            run   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    cnt <= '0;
                    if (!lock_s) begin
                        state <= ST_WAIT;
                        run   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                    run   <= 1'b0;
                end
            endcase
        end
    end

    // Accumulation is suppressed on the edge that sees lock loss, so acc/ce clear there.
    always_comb begin
        accum_en = (state == ST_RUN) && lock_s;
        ready_c  = 1'b0;
        wr_hit   = '0;
        for (int i = 0; i < NCH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
            if (inc_sel == SEL_W'(i)) begin
                ready_c   = ~pend[i];
                wr_hit[i] = inc_wr & ~pend[i];
            end
        end
    end

    assign inc_ready = ready_c;

    // A staged increment swaps in only on a carry edge, keeping every period whole.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i]  <= '0;
                inc[i]  <= INC_INIT[i*ACC_W +: ACC_W];
                pval[i] <= '0;
            end
            pend <= '0;
            ce   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (accum_en) begin
                    acc[i] <= sum[i][ACC_W-1:0];
                    ce[i]  <= sum[i][ACC_W];
                end else begin
                    acc[i] <= '0;
                    ce[i]  <= 1'b0;
                end
                if (wr_hit[i]) begin
                    pval[i] <= inc_data;
                    pend[i] <= 1'b1;
                end else if (pend[i] && (!accum_en || sum[i][ACC_W])) begin
                    inc[i]  <= pval[i];
                    pend[i] <= 1'b0;
                end
            end
        end
    end

endmodule
